uart_var_frame: RTL

Runtime-configurable UART transceiver: baud divisor, data length (5–8 bits), parity (none/even/odd) and stop bits (1/2) all set per frame from input ports. RX reports parity, framing and overrun errors. Sits between the board serial pins and the command/register logic that drives DDS parameter writes, replacing fixed 8N1 links where host framing must change without re-synthesis.

---
 rtl/uart_var_frame_pkg.sv | 9 +
 rtl/uart_var_frame_rx.sv | 99 +++++++++
 rtl/uart_var_frame.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_var_frame_pkg.sv
// uart_var_frame_pkg: shared parity codes, FSM states and config decode for uart_var_frame
package uart_var_frame_pkg;
  typedef enum logic [1:0] {par_none, par_even, par_odd, par_none_alt} parity_t;
  typedef enum logic [2:0] {s_idle, s_start, s_data, s_parity, s_stop} state_t;
  localparam int min_limit = 3;
  function automatic logic [3:0] data_len(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction
endpackage

// File: rtl/uart_var_frame_rx.sv
// uart_var_frame_rx: rx synchroniser, receive FSM and sticky status flags
// Parity checking present only with UART_VAR_FRAME_PARITY_EN defined.
module uart_var_frame_rx
  import uart_var_frame_pkg::*;
#(
  parameter int limit_width = 16,
  parameter int sync_stages = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [limit_width-1:0] limit,
  input  logic [2:0]             last,
  input  logic [1:0]             parity_mode,
  input  logic                   rx,
  input  logic                   rx_clr,
  output logic [7:0]             rx_data,
  output logic                   rx_rec_flag,
  output logic                   rx_parity_err,
  output logic                   rx_frame_err,
  output logic                   rx_overrun
);
  localparam int stages = sync_stages < 2 ? 2 : sync_stages;
  state_t state, state_n;
  logic [stages-1:0] sync;
  logic [limit_width-1:0] cnt, lim_r;
  logic [2:0] idx, last_r;
  logic [7:0] sh;
  logic rx_s, rx_prev, fall, tick, mid, done, par_en_r;
  assign rx_s = sync[stages-1];
  assign fall = rx_prev & ~rx_s;
  assign tick = cnt == lim_r;
  assign mid = cnt == (lim_r >> 1);
  assign done = state == s_stop && tick;
  always_ff @(posedge clk) state <= rst ? s_idle : state_n;
  always_comb begin
    state_n = state;
    case (state)
      s_idle:   state_n = fall ? s_start : s_idle;
      s_start:  state_n = mid ? (rx_s ? s_idle : s_data) : s_start;
      s_data:   state_n = tick && idx == last_r ? (par_en_r ? s_parity : s_stop) : s_data;
      s_parity: state_n = tick ? s_stop : s_parity;
      s_stop:   state_n = tick ? s_idle : s_stop;
      default:  state_n = s_idle;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      rx_prev <= 1'b1;
      cnt <= '0;
      lim_r <= '0;
      idx <= '0;
      last_r <= '0;
      sh <= '0;
      rx_data <= '0;
      {rx_rec_flag, rx_frame_err, rx_overrun} <= '0;
    end else begin
      sync <= {sync[stages-2:0], rx};
      rx_prev <= rx_s;
      cnt <= state == s_idle || state_n != state || tick ? '0 : cnt + limit_width'(1);
      idx <= state != s_data || state_n != state ? '0 : tick ? idx + 3'd1 : idx;
      if (state == s_idle) begin
        lim_r <= limit;
        last_r <= last;
      end
      if (state == s_data && tick) sh <= {rx_s, sh[7:1]};
      if (rx_clr) {rx_rec_flag, rx_frame_err, rx_overrun} <= '0;
      if (done && rx_rec_flag) rx_overrun <= 1'b1;
      if (done && !rx_rec_flag) begin
        rx_data <= sh >> (3'd7 - last_r);
        rx_rec_flag <= 1'b1;
        rx_frame_err <= ~rx_s | (rx_frame_err & ~rx_clr);
      end
    end
  end
`ifdef UART_VAR_FRAME_PARITY_EN
  logic odd_r, acc, perr_r;
  always_ff @(posedge clk) begin
    if (rst) {par_en_r, odd_r, acc, perr_r, rx_parity_err} <= '0;
    else begin
      if (state == s_idle) begin
        par_en_r <= parity_mode == par_even || parity_mode == par_odd;
        odd_r <= parity_mode == par_odd;
        acc <= 1'b0;
        perr_r <= 1'b0;
      end
      if (state == s_data && tick) acc <= acc ^ rx_s;
      if (state == s_parity && tick) perr_r <= rx_s != (acc ^ odd_r);
      if (rx_clr) rx_parity_err <= 1'b0;
      if (done && !rx_rec_flag) rx_parity_err <= perr_r | (rx_parity_err & ~rx_clr);
    end
  end
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
  assign par_en_r = 1'b0;
  assign rx_parity_err = 1'b0;
`endif
endmodule

// File: rtl/uart_var_frame.sv
// uart_var_frame: runtime-configurable UART transceiver, TX here, RX in uart_var_frame_rx
// Define UART_VAR_FRAME_PARITY_EN to enable parity generation and checking.
module uart_var_frame
  import uart_var_frame_pkg::*;
#(
  parameter int clock_freq  = 100_000_000,
  parameter int limit_width = 16,
  parameter int sync_stages = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [limit_width-1:0] baud_limit,
  input  logic [1:0]             data_bits,
  input  logic [1:0]             parity_mode,
  input  logic                   stop_bits,
  input  logic [7:0]             tx_data,
  input  logic                   tx_start,
  output logic                   tx,
  output logic                   tx_idle,
  output logic                   tx_done,
  input  logic                   rx,
  input  logic                   rx_clr,
  output logic [7:0]             rx_data,
  output logic                   rx_rec_flag,
  output logic                   rx_parity_err,
  output logic                   rx_frame_err,
  output logic                   rx_overrun
);
  state_t state, state_n;
  logic [limit_width-1:0] lim, cnt, lim_r;
  logic [2:0] last, idx, last_r;
  logic [7:0] mask, sh;
  logic two_r, tick, par_en_r, par_bit_r, unused_cfg;
  assign unused_cfg = clock_freq[0];
  assign lim = baud_limit < limit_width'(min_limit) ? limit_width'(min_limit) : baud_limit;
  assign last = 3'(data_len(data_bits) - 4'd1);
  assign mask = 8'hff >> (3'd7 - last);
  assign tick = cnt == lim_r;
  assign tx_idle = state == s_idle;
  assign tx = state == s_start ? 1'b0 : state == s_data ? sh[0] : state == s_parity ? par_bit_r : 1'b1;
  always_ff @(posedge clk) state <= rst ? s_idle : state_n;
  always_comb begin
    state_n = state;
    case (state)
      s_idle:   state_n = tx_start ? s_start : s_idle;
      s_start:  state_n = tick ? s_data : s_start;
      s_data:   state_n = tick && idx == last_r ? (par_en_r ? s_parity : s_stop) : s_data;
      s_parity: state_n = tick ? s_stop : s_parity;
      s_stop:   state_n = tick && idx == {2'b00, two_r} ? s_idle : s_stop;
      default:  state_n = s_idle;
    endcase
  end
  // config is reloaded every idle cycle, so the accepting edge freezes it for the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      lim_r <= '0;
      last_r <= '0;
      two_r <= 1'b0;
      sh <= '0;
      tx_done <= 1'b0;
    end else begin
      cnt <= state == s_idle || tick ? '0 : cnt + limit_width'(1);
      idx <= state_n != state ? '0 : tick ? idx + 3'd1 : idx;
      tx_done <= state == s_stop && state_n == s_idle;
      if (state == s_idle) begin
        lim_r <= lim;
        last_r <= last;
        two_r <= stop_bits;
        sh <= tx_data & mask;
      end else if (state == s_data && tick) sh <= sh >> 1;
    end
  end
`ifdef UART_VAR_FRAME_PARITY_EN
  always_ff @(posedge clk)
    if (rst) {par_en_r, par_bit_r} <= '0;
    else if (state == s_idle) begin
      par_en_r <= parity_mode == par_even || parity_mode == par_odd;
      par_bit_r <= ^(tx_data & mask) ^ (parity_mode == par_odd);
    end
`else
  assign {par_en_r, par_bit_r} = 2'b00;
`endif
  uart_var_frame_rx #(.limit_width(limit_width), .sync_stages(sync_stages)) u_rx (
    .clk(clk),
    .rst(rst),
    .limit(lim),
    .last(last),
    .parity_mode(parity_mode),
    .rx(rx),
    .rx_clr(rx_clr),
    .rx_data(rx_data),
    .rx_rec_flag(rx_rec_flag),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun)
  );
endmodule
